// File: rtl/float_add_arbiter_if.sv
// Bundles the client request lanes, the shared adder connection and the result port
// of float_add_arbiter; the arbiter uses the slave view, the surrounding logic the master view.
interface float_add_arbiter_if #(
    parameter int FLOAT_SIZE     = 32,
    parameter int NUM_REQUESTERS = 4,
    parameter int ID_W           = $clog2(NUM_REQUESTERS)
);
    logic [NUM_REQUESTERS-1:0]            reqValid;
    logic [NUM_REQUESTERS-1:0]            reqReady;
    logic [NUM_REQUESTERS*FLOAT_SIZE-1:0] reqA;
    logic [NUM_REQUESTERS*FLOAT_SIZE-1:0] reqB;
    logic [FLOAT_SIZE-1:0]                addA;
    logic [FLOAT_SIZE-1:0]                addB;
    logic [FLOAT_SIZE-1:0]                addSum;
    logic                                 resValid;
    logic                                 resReady;
    logic [ID_W-1:0]                      resId;
    logic [FLOAT_SIZE-1:0]                resSum;
    logic                                 idle;

    modport slave (
        input  reqValid, reqA, reqB, addSum, resReady,
        output reqReady, addA, addB, resValid, resId, resSum, idle
    );

    modport master (
        output reqValid, reqA, reqB, addSum, resReady,
        input  reqReady, addA, addB, resValid, resId, resSum, idle
    );
endinterface

// File: rtl/float_add_arbiter.sv
// Round-robin sharing of one fixed-latency pipelined float adder between several clients,
// with results returned in issue order through a credit-protected first-word-fall-through FIFO.
module float_add_arbiter #(
    parameter int MANTISSA_SIZE  = 23,
    parameter int EXPONENT_SIZE  = 8,
    parameter int NUM_REQUESTERS = 4,
    parameter int ADD_LATENCY    = 4,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    float_add_arbiter_if.slave      io_bus
);
    localparam int FLOAT_SIZE = 1 + EXPONENT_SIZE + MANTISSA_SIZE;
    localparam int ID_W       = $clog2(NUM_REQUESTERS);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    logic [ID_W-1:0]                 r_rrPointer;
    logic [CNT_W-1:0]                r_credit;
    logic [ADD_LATENCY:0]            r_tagValid;
    logic [ADD_LATENCY:0][ID_W-1:0]  r_tagId;
    logic [FLOAT_SIZE-1:0]           r_addA;
    logic [FLOAT_SIZE-1:0]           r_addB;
    logic [ID_W-1:0]                 r_fifoId  [FIFO_DEPTH];
    logic [FLOAT_SIZE-1:0]           r_fifoSum [FIFO_DEPTH];
    logic [PTR_W:0]                  r_wrPtr;
    logic [PTR_W:0]                  r_rdPtr;

    logic                            w_found;
    logic [ID_W-1:0]                 w_grantIdx;
    logic                            w_canIssue;
    logic                            w_handshake;
    logic                            w_push;
    logic                            w_pop;
    logic                            w_resValid;
    logic [NUM_REQUESTERS-1:0]       w_reqReady;

    function automatic logic [ID_W-1:0] rrIndex(input logic [ID_W-1:0] base, input int offset);
        return ID_W'((int'(base) + offset) % NUM_REQUESTERS);
    endfunction

    always_comb begin
        w_found    = 1'b0;
        w_grantIdx = '0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            if (!w_found && io_bus.reqValid[rrIndex(r_rrPointer, k)]) begin
                w_found    = 1'b1;
                w_grantIdx = rrIndex(r_rrPointer, k);
            end
        end
    end

    // Credit counts every op between issue and pop, so a full credit means the FIFO can
    // absorb everything still in the adder; no grant while reset is held.
    assign w_canIssue  = !reset && (r_credit < CNT_W'(FIFO_DEPTH));
    assign w_handshake = w_canIssue && w_found;
    assign w_push      = r_tagValid[ADD_LATENCY];
    assign w_resValid  = (r_wrPtr != r_rdPtr);
    assign w_pop       = w_resValid && io_bus.resReady;

    always_comb begin
        w_reqReady = '0;
        if (w_handshake) begin
            w_reqReady[w_grantIdx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rrPointer <= '0;
            r_credit    <= '0;
            r_tagValid  <= '0;
            r_tagId     <= '0;
            r_addA      <= '0;
            r_addB      <= '0;
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
        end else begin
            r_tagValid <= {r_tagValid[ADD_LATENCY-1:0], w_handshake};
            r_tagId    <= {r_tagId[ADD_LATENCY-1:0], w_grantIdx};
            if (w_handshake) begin
                r_addA      <= io_bus.reqA[w_grantIdx*FLOAT_SIZE +: FLOAT_SIZE];
                r_addB      <= io_bus.reqB[w_grantIdx*FLOAT_SIZE +: FLOAT_SIZE];
                r_rrPointer <= rrIndex(w_grantIdx, 1);
            end
            if (w_handshake && !w_pop) begin
                r_credit <= r_credit + CNT_W'(1);
            end else if (!w_handshake && w_pop) begin
                r_credit <= r_credit - CNT_W'(1);
            end
            if (w_push) begin
                r_wrPtr <= r_wrPtr + (PTR_W+1)'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifoId[r_wrPtr[PTR_W-1:0]]  <= r_tagId[ADD_LATENCY];
            r_fifoSum[r_wrPtr[PTR_W-1:0]] <= io_bus.addSum;
        end
    end

    assign io_bus.reqReady = w_reqReady;
    assign io_bus.addA     = r_addA;
    assign io_bus.addB     = r_addB;
    assign io_bus.resValid = w_resValid;
    assign io_bus.resId    = r_fifoId[r_rdPtr[PTR_W-1:0]];
    assign io_bus.resSum   = r_fifoSum[r_rdPtr[PTR_W-1:0]];
    assign io_bus.idle     = (r_credit == '0);
endmodule
